lif_post_neuron: RTL and testbench

- Leaky integrate-and-fire postsynaptic neuron that generates the `post_spike` consumed by the STDP learning block.
- Consumes the same 4-bit `pre_spike` bus and the packed 16-bit `weight` bus that the learning block produces.
- Closes the learning loop: pre spikes are integrated through the weights into a membrane potential, and a spike fires on threshold.
- Includes a refractory period and an activity counter for observation.

---
 rtl/snn_pkg.sv | 11 +
 rtl/lif_post_neuron_if.sv | 13 +
 rtl/syn_weight_sum.sv | 14 +
 rtl/lif_post_neuron.sv | 84 ++++++++
 tb/tb_lif_post_neuron.sv | 113 +++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared SNN types, widths and weight-slice helper for the neuron and STDP blocks
package snn_pkg;
  localparam int NUM_PRE = 4;
  localparam int W_WIDTH = 4;
  localparam int POT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, INTEGRATE, REFRACTORY} state_e;
  // pre 0 owns the most significant weight slice
  function automatic int w_lsb(int i);
    return (NUM_PRE - 1 - i) * W_WIDTH;
  endfunction
endpackage

// File: rtl/lif_post_neuron_if.sv
// lif_post_neuron_if: spike/weight inputs and observation outputs of the LIF neuron
interface lif_post_neuron_if;
  import snn_pkg::*;
  logic enable;
  logic [NUM_PRE-1:0] pre_spike;
  logic [NUM_PRE*W_WIDTH-1:0] weight;
  logic post_spike;
  logic [POT_WIDTH-1:0] membrane;
  logic refractory;
  logic [7:0] spike_count;
  modport master(output enable, pre_spike, weight, input post_spike, membrane, refractory, spike_count);
  modport slave(input enable, pre_spike, weight, output post_spike, membrane, refractory, spike_count);
endinterface

// File: rtl/syn_weight_sum.sv
// syn_weight_sum: masked sum of the weights whose presynaptic input spiked
module syn_weight_sum
  import snn_pkg::*;
(
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic [POT_WIDTH:0]         syn
);
  always_comb begin
    syn = '0;
    for (int i = 0; i < NUM_PRE; i++)
      syn = syn + (pre_spike[i] ? (POT_WIDTH+1)'(weight[w_lsb(i) +: W_WIDTH]) : '0);
  end
endmodule

// File: rtl/lif_post_neuron.sv
// lif_post_neuron: leaky integrate-and-fire neuron with refractory period and spike counter
module lif_post_neuron
  import snn_pkg::*;
#(
  parameter int THRESHOLD = 32,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  lif_post_neuron_if.slave bus
);
  localparam int PW = POT_WIDTH;
  state_e state_q, state_d;
  logic [PW-1:0] mem_q, mem_d;
  logic post_q, post_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rc_q, rc_d;
  logic [PW:0] syn;
  logic [PW-1:0] shr, leak, cand;
  logic [PW+1:0] cand_w;
  logic fire;
  syn_weight_sum u_sum (.pre_spike(bus.pre_spike), .weight(bus.weight), .syn(syn));
  // leak never exceeds membrane, so the wide candidate cannot underflow
  always_comb begin
    shr = mem_q >> LEAK_SHIFT;
    leak = mem_q == '0 ? '0 : (shr == '0 ? PW'(1) : shr);
    cand_w = {2'b00, mem_q} - {2'b00, leak} + {1'b0, syn};
    cand = cand_w > (PW+2)'((1 << PW) - 1) ? '1 : cand_w[PW-1:0];
    fire = cand >= PW'(THRESHOLD);
  end
  always_comb begin
    state_d = state_q;
    mem_d = mem_q;
    post_d = 1'b0;
    cnt_d = cnt_q;
    rc_d = rc_q;
    case (state_q)
      IDLE: begin
        mem_d = '0;
        state_d = bus.enable ? INTEGRATE : IDLE;
      end
      INTEGRATE: begin
        if (!bus.enable) begin
          state_d = IDLE;
          mem_d = '0;
        end else if (fire) begin
          post_d = 1'b1;
          mem_d = '0;
          cnt_d = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
          state_d = REFRACTORY;
          rc_d = 4'(REFRAC_CYCLES);
        end else begin
          mem_d = cand;
        end
      end
      REFRACTORY: begin
        mem_d = '0;
        rc_d = rc_q - 4'd1;
        state_d = !bus.enable ? IDLE : (rc_q == 4'd1 ? INTEGRATE : REFRACTORY);
      end
      default: state_d = INTEGRATE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INTEGRATE;
      mem_q <= '0;
      post_q <= 1'b0;
      cnt_q <= '0;
      rc_q <= '0;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      post_q <= post_d;
      cnt_q <= cnt_d;
      rc_q <= rc_d;
    end
  end
  assign bus.post_spike = post_q;
  assign bus.membrane = mem_q;
  assign bus.refractory = state_q == REFRACTORY;
  assign bus.spike_count = cnt_q;
endmodule

// File: tb/tb_lif_post_neuron.sv
// tb_lif_post_neuron: directed checks of integration, leak, refractory, saturation and reset
module tb_lif_post_neuron;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int pulses;
  int leak_seq [21] = '{25, 22, 20, 18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
  int sat_seq [5] = '{60, 113, 159, 200, 235};
  always #5 clk = ~clk;
  lif_post_neuron_if if0 ();
  lif_post_neuron_if if1 ();
  lif_post_neuron dut0 (.clk(clk), .rst(rst), .bus(if0));
  lif_post_neuron #(.THRESHOLD(255)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input int post, input int mem, input int refr, input int cnt);
    chk({tag, ".post"}, 32'(if0.post_spike), 32'(post));
    chk({tag, ".mem"}, 32'(if0.membrane), 32'(mem));
    chk({tag, ".refr"}, 32'(if0.refractory), 32'(refr));
    chk({tag, ".cnt"}, 32'(if0.spike_count), 32'(cnt));
  endtask

  initial begin
    if0.enable = 1'b1; if0.pre_spike = 4'b0001; if0.weight = 16'h8000;
    if1.enable = 1'b0; if1.pre_spike = 4'b1111; if1.weight = 16'hFFFF;
    #3;
    chk0("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // single input integration up to the fire
    step(); chk0("s1_a", 0, 8, 0, 0);
    step(); chk0("s1_b", 0, 15, 0, 0);
    step(); chk0("s1_c", 0, 22, 0, 0);
    step(); chk0("s1_d", 0, 28, 0, 0);
    step(); chk0("s1_fire", 1, 0, 1, 1);
    step(); chk0("s1_r1", 0, 0, 1, 1);
    step(); chk0("s1_r2", 0, 0, 1, 1);
    step(); chk0("s1_r3", 0, 0, 0, 1);
    step(); chk0("s1_resume", 0, 8, 0, 1);
    // climb back to 28 and let it leak away
    step(); step(); step(); chk0("leak_start", 0, 28, 0, 1);
    if0.pre_spike = 4'b0000;
    for (int i = 0; i < 21; i++) begin
      step();
      chk($sformatf("leak_%0d", i), 32'(if0.membrane), 32'(leak_seq[i]));
      chk($sformatf("leak_post_%0d", i), 32'(if0.post_spike), 32'd0);
    end
    // all-zero weights never fire
    if0.weight = 16'h0000; if0.pre_spike = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    chk0("zero_w", 0, 0, 0, 1);
    // enable drop mid-integration
    if0.weight = 16'h8000; if0.pre_spike = 4'b0001;
    step(); step(); chk0("en_a", 0, 15, 0, 1);
    if0.enable = 1'b0;
    step(); chk0("en_off", 0, 0, 0, 1);
    if0.enable = 1'b1;
    step(); chk0("en_wake", 0, 0, 0, 1);
    step(); chk0("en_int", 0, 8, 0, 1);
    // full drive: fire every 4 cycles, pre ignored while refractory
    if0.weight = 16'hFFFF; if0.pre_spike = 4'b1111;
    for (int p = 0; p < 3; p++) begin
      step(); chk0($sformatf("fd%0d_fire", p), 1, 0, 1, 2 + p);
      step(); chk0($sformatf("fd%0d_r1", p), 0, 0, 1, 2 + p);
      step(); chk0($sformatf("fd%0d_r2", p), 0, 0, 1, 2 + p);
      step(); chk0($sformatf("fd%0d_r3", p), 0, 0, 0, 2 + p);
    end
    // async reset mid-refractory
    step(); chk0("pre_rst", 1, 0, 1, 5);
    #2 rst = 1'b1;
    #1 chk0("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(); chk0("post_rst", 1, 0, 1, 1);
    // drive the counter into saturation
    pulses = 1;
    for (int i = 0; i < 259 * 4; i++) begin
      step();
      if (if0.post_spike) pulses++;
    end
    chk("pulse_total", 32'(pulses), 32'd260);
    chk("cnt_sat", 32'(if0.spike_count), 32'd255);
    for (int i = 0; i < 4; i++) step();
    chk0("cnt_hold", 1, 0, 1, 255);
    // potential saturation on the high-threshold instance
    if1.enable = 1'b1;
    step();
    chk("sat_wake", 32'(if1.membrane), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat_%0d", i), 32'(if1.membrane), 32'(sat_seq[i]));
      chk($sformatf("sat_post_%0d", i), 32'(if1.post_spike), 32'd0);
    end
    step();
    chk("sat_fire", 32'(if1.post_spike), 32'd1);
    chk("sat_mem", 32'(if1.membrane), 32'd0);
    chk("sat_cnt", 32'(if1.spike_count), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
